serial_add_ctrl: RTL

- Bit-serial add/subtract sequencer built around a single instance of the team's 1-bit `fulladder` cell.
- Accepts two WIDTH-bit operands through a start/ready handshake, then clocks them LSB-first through the adder, one bit per cycle.
- Holds the running carry in a flip-flop and assembles the result in a shift register.
- Purpose: lets the datapath trade WIDTH-1 adder cells for WIDTH cycles of latency; used by multicycle ALU ops.

---
 rtl/serial_add_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose: bit-serial add/subtract sequencer. Two WIDTH-bit operands are
// accepted through a start/ready handshake and then pushed LSB-first through
// a single 1-bit fulladder, one bit per clock. The running carry lives in a
// flip-flop and the result is assembled in a shift register. This trades
// WIDTH-1 adder cells for WIDTH cycles of latency in multicycle ALU ops.
//
// Ports:
//   clk    - system clock, rising-edge
//   rst    - synchronous active-high reset
//   start  - begin an operation (taken only while ready=1)
//   op_sub - 0: a+b+cin, 1: a-b (cin ignored)
//   a, b   - WIDTH-bit operands, captured on an accepted start
//   cin    - carry-in for add, captured on an accepted start
//   ready  - high only while idle
//   done   - one-cycle pulse; sum/cout/ovf are valid in this cycle
//   sum    - result, held from done until the next done or reset
//   cout   - final carry-out (for subtract, 1 means no borrow)
//   ovf    - signed overflow (carry into MSB xor carry out of MSB)
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// fulladder
//
// Purpose: the 1-bit full adder cell used by the serial datapath.
//
// Ports:
//   a, b, cin - addend bits and carry-in
//   s         - sum bit
//   cout      - carry-out
// ----------------------------------------------------------------------------
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has arrived at bit 0. Written as shift/or so it also
    // holds for WIDTH=1 without a degenerate part-select.
    assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs. ready/done are derived from the next
    // state so they line up with the state register without any
    // combinational path from inputs to outputs. The result registers are
    // loaded on the final RUN cycle so they are already valid while done is
    // high; at that moment 'carry' is the carry into the MSB, so the overflow
    // flag is formed directly from it and the adder's carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready  <= 1'b1;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
        end else begin
            ready <= (next_state == IDLE);
            done  <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= op_sub ? ~b : b;
                        carry  <= op_sub ? 1'b1 : cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= sum_shift;
                        cout <= fa_cout;
                        ovf  <= carry ^ fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
